block_stream_master: RTL

- Avalon-MM bus master that moves 64-bit plaintext blocks from system memory into the cipher datapath, then writes the 64-bit cipher results back to memory.
- It is the initiator counterpart of the CSR slave: the host programs source, destination and block count, then pulses start.
- One block is in flight at a time: read block, hand it to the cipher, take the result, write it back, repeat.

---
 rtl/block_stream_master.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/block_stream_master.sv
// Avalon-MM master that streams 64-bit blocks from memory through the cipher
// and writes the results back, one block in flight at a time.
module block_stream_master #(
  parameter int unsigned ADDRESSWIDTH = 26,
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned BLKWIDTH     = 64,
  parameter int unsigned CNTWIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] src_base,
  input  logic [ADDRESSWIDTH-1:0] dst_base,
  input  logic [CNTWIDTH-1:0]     num_blocks,
  output logic                    busy,
  output logic                    done,
  output logic [CNTWIDTH-1:0]     blk_cnt,
  output logic [BLKWIDTH-1:0]     blk_out_data,
  output logic                    blk_out_valid,
  input  logic                    blk_out_ready,
  input  logic [BLKWIDTH-1:0]     blk_in_data,
  input  logic                    blk_in_valid,
  output logic                    blk_in_ready,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic                    master_read,
  output logic                    master_write,
  output logic [DATAWIDTH-1:0]    master_writedata,
  input  logic [DATAWIDTH-1:0]    master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    master_waitrequest
);

  localparam logic [ADDRESSWIDTH-1:0] WORD_BYTES = ADDRESSWIDTH'(DATAWIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_PUSH, S_PULL, S_WR_REQ, S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESSWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTWIDTH-1:0]     remaining_q, remaining_d;
  logic                    w_q, w_d;
  logic [BLKWIDTH-1:0]     blk_buf_q, blk_buf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CNTWIDTH-1:0]     blk_cnt_q, blk_cnt_d;
  logic                    blk_out_valid_q, blk_out_valid_d;
  logic                    blk_in_ready_q, blk_in_ready_d;
  logic [ADDRESSWIDTH-1:0] master_address_q, master_address_d;
  logic                    master_read_q, master_read_d;
  logic                    master_write_q, master_write_d;
  logic [DATAWIDTH-1:0]    master_writedata_q, master_writedata_d;

  // State and registered outputs; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      remaining_q        <= '0;
      w_q                <= 1'b0;
      blk_buf_q          <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      blk_cnt_q          <= '0;
      blk_out_valid_q    <= 1'b0;
      blk_in_ready_q     <= 1'b0;
      master_address_q   <= '0;
      master_read_q      <= 1'b0;
      master_write_q     <= 1'b0;
      master_writedata_q <= '0;
    end else begin
      state_q            <= state_d;
      rd_ptr_q           <= rd_ptr_d;
      wr_ptr_q           <= wr_ptr_d;
      remaining_q        <= remaining_d;
      w_q                <= w_d;
      blk_buf_q          <= blk_buf_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      blk_cnt_q          <= blk_cnt_d;
      blk_out_valid_q    <= blk_out_valid_d;
      blk_in_ready_q     <= blk_in_ready_d;
      master_address_q   <= master_address_d;
      master_read_q      <= master_read_d;
      master_write_q     <= master_write_d;
      master_writedata_q <= master_writedata_d;
    end
  end

  // Next state; outputs are set up one cycle ahead for the state being entered.
  always_comb begin
    state_d            = state_q;
    rd_ptr_d           = rd_ptr_q;
    wr_ptr_d           = wr_ptr_q;
    remaining_d        = remaining_q;
    w_d                = w_q;
    blk_buf_d          = blk_buf_q;
    busy_d             = busy_q;
    done_d             = 1'b0;
    blk_cnt_d          = blk_cnt_q;
    blk_out_valid_d    = blk_out_valid_q;
    blk_in_ready_d     = blk_in_ready_q;
    master_address_d   = master_address_q;
    master_read_d      = master_read_q;
    master_write_d     = master_write_q;
    master_writedata_d = master_writedata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_blocks == '0) begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            rd_ptr_d         = src_base;
            wr_ptr_d         = dst_base;
            remaining_d      = num_blocks;
            blk_cnt_d        = '0;
            w_d              = 1'b0;
            busy_d           = 1'b1;
            master_read_d    = 1'b1;
            master_address_d = src_base;
            state_d          = S_RD_REQ;
          end
        end
      end

      S_RD_REQ: begin
        if (!master_waitrequest) begin
          master_read_d = 1'b0;
          state_d       = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (master_readdatavalid) begin
          if (!w_q) begin
            blk_buf_d[BLKWIDTH-1 -: DATAWIDTH] = master_readdata;
          end else begin
            blk_buf_d[DATAWIDTH-1:0] = master_readdata;
          end
          rd_ptr_d = rd_ptr_q + WORD_BYTES;
          w_d      = ~w_q;
          if (!w_q) begin
            master_read_d    = 1'b1;
            master_address_d = rd_ptr_q + WORD_BYTES;
            state_d          = S_RD_REQ;
          end else begin
            blk_out_valid_d = 1'b1;
            state_d         = S_PUSH;
          end
        end
      end

      S_PUSH: begin
        if (blk_out_ready) begin
          blk_out_valid_d = 1'b0;
          blk_in_ready_d  = 1'b1;
          state_d         = S_PULL;
        end
      end

      S_PULL: begin
        if (blk_in_valid) begin
          blk_buf_d          = blk_in_data;
          blk_in_ready_d     = 1'b0;
          w_d                = 1'b0;
          master_write_d     = 1'b1;
          master_address_d   = wr_ptr_q;
          master_writedata_d = blk_in_data[BLKWIDTH-1 -: DATAWIDTH];
          state_d            = S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        if (!master_waitrequest) begin
          wr_ptr_d = wr_ptr_q + WORD_BYTES;
          w_d      = ~w_q;
          if (!w_q) begin
            master_address_d   = wr_ptr_q + WORD_BYTES;
            master_writedata_d = blk_buf_q[DATAWIDTH-1:0];
          end else begin
            master_write_d = 1'b0;
            blk_cnt_d      = blk_cnt_q + CNTWIDTH'(1);
            remaining_d    = remaining_q - CNTWIDTH'(1);
            if (remaining_q == CNTWIDTH'(1)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_FINISH;
            end else begin
              master_read_d    = 1'b1;
              master_address_d = rd_ptr_q;
              state_d          = S_RD_REQ;
            end
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign blk_cnt          = blk_cnt_q;
  assign blk_out_data     = blk_buf_q;
  assign blk_out_valid    = blk_out_valid_q;
  assign blk_in_ready     = blk_in_ready_q;
  assign master_address   = master_address_q;
  assign master_read      = master_read_q;
  assign master_write     = master_write_q;
  assign master_writedata = master_writedata_q;

endmodule
